// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI AW/AR command into len+1 beats with FIXED/INCR/WRAP addressing,
// byte-lane strobes, last flag and a protocol-error flag; one burst in flight at a time.
//
// state | meaning
// IDLE  | cmd_ready_o high, waiting for a command handshake
// BURST | presenting beats 0..len, command port closed
module axi_burst_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ID_WIDTH-1:0]     cmd_id_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [7:0]              cmd_len_i,
    input  logic [2:0]              cmd_size_i,
    input  logic [1:0]              cmd_burst_i,
    output logic                    beat_valid_o,
    input  logic                    beat_ready_i,
    output logic [ID_WIDTH-1:0]     beat_id_o,
    output logic [ADDR_WIDTH-1:0]   beat_addr_o,
    output logic [7:0]              beat_idx_o,
    output logic [DATA_WIDTH/8-1:0] beat_strb_o,
    output logic                    beat_last_o,
    output logic                    beat_err_o
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int LOG2NB = $clog2(NB);
    localparam logic [ADDR_WIDTH-1:0] NB_MASK = ADDR_WIDTH'(NB - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
    localparam logic [1:0] B_FIXED = 2'b00;
    localparam logic [1:0] B_INCR  = 2'b01;
    localparam logic [1:0] B_WRAP  = 2'b10;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic                    valid_q, valid_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              idx_q, idx_d;
    logic [NB-1:0]           strb_q, strb_d;
    logic                    last_q, last_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;

    logic [ADDR_WIDTH-1:0]   c_bytes, c_aligned, c_end;
    logic                    c_err;
    logic [ADDR_WIDTH-1:0]   b_bytes, b_incr, wrap_len, wrap_lo, next_addr;

    // Lanes from the (possibly unaligned) byte offset up to the end of the aligned S-byte slot.
    function automatic logic [NB-1:0] lane_mask(input logic [ADDR_WIDTH-1:0] a,
                                                input logic [2:0] sz);
        logic [ADDR_WIDTH-1:0] bytes;
        int lo;
        int hi;
        bytes = ONE << sz;
        lo    = int'(a & NB_MASK);
        hi    = int'((a & ~(bytes - ONE)) & NB_MASK) + int'(bytes) - 1;
        lane_mask = '0;
        for (int i = 0; i < NB; i++) begin
            if (i >= lo && i <= hi) lane_mask[i] = 1'b1;
        end
    endfunction

    always_comb begin
        c_bytes   = ONE << cmd_size_i;
        c_aligned = cmd_addr_i & ~(c_bytes - ONE);
        c_end     = c_aligned + ((ADDR_WIDTH'(cmd_len_i) + ONE) << cmd_size_i) - ONE;
        c_err = (int'(cmd_size_i) > LOG2NB)
              | (cmd_burst_i == 2'b11)
              | ((cmd_burst_i == B_WRAP) && !(cmd_len_i inside {8'd1, 8'd3, 8'd7, 8'd15}))
              | ((cmd_burst_i == B_WRAP) && ((cmd_addr_i & (c_bytes - ONE)) != '0))
              | ((cmd_burst_i == B_FIXED) && (cmd_len_i > 8'd15))
              | ((cmd_burst_i == B_INCR) && (((c_end ^ cmd_addr_i) >> 12) != '0));
    end

    always_comb begin
        b_bytes  = ONE << size_q;
        b_incr   = (addr_q & ~(b_bytes - ONE)) + b_bytes;
        wrap_len = (ADDR_WIDTH'(len_q) + ONE) << size_q;
        wrap_lo  = cmd_addr_q & ~(wrap_len - ONE);
        case (burst_q)
            B_FIXED: next_addr = cmd_addr_q;
            B_WRAP:  next_addr = (b_incr == wrap_lo + wrap_len) ? wrap_lo : b_incr;
            default: next_addr = b_incr;
        endcase
        if (err_q) next_addr = cmd_addr_q;
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        id_d       = id_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        strb_d     = strb_q;
        last_d     = last_q;
        err_d      = err_q;
        cmd_addr_d = cmd_addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d    = BURST;
                    valid_d    = 1'b1;
                    id_d       = cmd_id_i;
                    addr_d     = cmd_addr_i;
                    idx_d      = 8'd0;
                    strb_d     = c_err ? '0 : lane_mask(cmd_addr_i, cmd_size_i);
                    last_d     = (cmd_len_i == 8'd0);
                    err_d      = c_err;
                    cmd_addr_d = cmd_addr_i;
                    len_d      = cmd_len_i;
                    size_d     = cmd_size_i;
                    burst_d    = cmd_burst_i;
                end
            end
            BURST: begin
                if (beat_ready_i) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        id_d    = '0;
                        addr_d  = '0;
                        idx_d   = 8'd0;
                        strb_d  = '0;
                        last_d  = 1'b0;
                        err_d   = 1'b0;
                    end else begin
                        idx_d  = idx_q + 8'd1;
                        addr_d = next_addr;
                        strb_d = err_q ? '0 : lane_mask(next_addr, size_q);
                        last_d = ((idx_q + 8'd1) == len_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            idx_q      <= 8'd0;
            strb_q     <= '0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            cmd_addr_q <= '0;
            len_q      <= 8'd0;
            size_q     <= 3'd0;
            burst_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            strb_q     <= strb_d;
            last_q     <= last_d;
            err_q      <= err_d;
            cmd_addr_q <= cmd_addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
        end
    end

    assign cmd_ready_o  = (state_q == IDLE);
    assign beat_valid_o = valid_q;
    assign beat_id_o    = id_q;
    assign beat_addr_o  = addr_q;
    assign beat_idx_o   = idx_q;
    assign beat_strb_o  = strb_q;
    assign beat_last_o  = last_q;
    assign beat_err_o   = err_q;
endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Bench for axi_burst_addr_gen: directed commands push expected beats into a queue,
// a negedge monitor pops and compares every beat handshake.
module tb_axi_burst_addr_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_id = '0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic [1:0]  cmd_burst = '0;
    logic        beat_valid;
    logic        beat_ready = 1'b1;
    logic [3:0]  beat_id;
    logic [31:0] beat_addr;
    logic [7:0]  beat_idx;
    logic [7:0]  beat_strb;
    logic        beat_last;
    logic        beat_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  idx;
        logic [7:0]  strb;
        logic        last;
        logic        err;
    } beat_t;
    beat_t exp_q[$];

    axi_burst_addr_gen dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_id_i(cmd_id),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_size_i(cmd_size),
        .cmd_burst_i(cmd_burst),
        .beat_valid_o(beat_valid), .beat_ready_i(beat_ready), .beat_id_o(beat_id),
        .beat_addr_o(beat_addr), .beat_idx_o(beat_idx), .beat_strb_o(beat_strb),
        .beat_last_o(beat_last), .beat_err_o(beat_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] idx,
                        input logic [7:0] strb, input logic last, input logic err);
        beat_t b;
        b.id = id; b.addr = addr; b.idx = idx; b.strb = strb; b.last = last; b.err = err;
        exp_q.push_back(b);
    endtask

    // Monitor: every beat handshake must match the head of the expected queue.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && beat_valid && beat_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: got id=%0h addr=%0h idx=%0d, expected no beat",
                             beat_id, beat_addr, beat_idx);
                end else begin
                    e = exp_q.pop_front();
                    if ({beat_id, beat_addr, beat_idx, beat_strb, beat_last, beat_err} !==
                        {e.id, e.addr, e.idx, e.strb, e.last, e.err}) begin
                        n_fail++;
                        $display("FAIL beat: got id=%0h addr=%0h idx=%0d strb=%0h last=%0b err=%0b, expected id=%0h addr=%0h idx=%0d strb=%0h last=%0b err=%0b",
                                 beat_id, beat_addr, beat_idx, beat_strb, beat_last, beat_err,
                                 e.id, e.addr, e.idx, e.strb, e.last, e.err);
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr;
        cmd_len = len; cmd_size = size; cmd_burst = burst;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("cmd_accept", 64'(ok), 64'd1);
        check("first_beat_latency", {59'd0, beat_valid, beat_id}, {59'd0, 1'b1, id});
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cmd_ready && exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        check(name, 64'(ok), 64'd1);
    endtask

    function automatic logic [63:0] out_vec();
        return {8'd0, cmd_ready, beat_valid, beat_id, beat_addr, beat_idx, beat_strb,
                beat_last, beat_err};
    endfunction

    localparam logic [63:0] RESET_VEC = {8'd0, 1'b1, 55'd0};

    initial begin
        int  stalls;
        bit  done;
        bit  last_hs;

        repeat (2) @(negedge clk);
        check("reset_outputs", out_vec(), RESET_VEC);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // INCR unaligned start
        push(4'd1, 32'h1004, 8'd0, 8'hF0, 1'b0, 1'b0);
        push(4'd1, 32'h1008, 8'd1, 8'h0F, 1'b0, 1'b0);
        push(4'd1, 32'h100C, 8'd2, 8'hF0, 1'b0, 1'b0);
        push(4'd1, 32'h1010, 8'd3, 8'h0F, 1'b1, 1'b0);
        send_cmd(4'd1, 32'h1004, 8'd3, 3'd2, 2'b01);
        wait_idle("incr_done");

        // WRAP across the 32-byte window
        push(4'd2, 32'h38, 8'd0, 8'hFF, 1'b0, 1'b0);
        push(4'd2, 32'h20, 8'd1, 8'hFF, 1'b0, 1'b0);
        push(4'd2, 32'h28, 8'd2, 8'hFF, 1'b0, 1'b0);
        push(4'd2, 32'h30, 8'd3, 8'hFF, 1'b1, 1'b0);
        send_cmd(4'd2, 32'h38, 8'd3, 3'd3, 2'b10);
        wait_idle("wrap_done");

        // FIXED unaligned
        for (int i = 0; i < 3; i++) push(4'd3, 32'h103, 8'(i), 8'h08, i == 2, 1'b0);
        send_cmd(4'd3, 32'h103, 8'd2, 3'd2, 2'b00);
        wait_idle("fixed_done");

        // INCR crossing 4KB -> error burst
        for (int i = 0; i < 2; i++) push(4'd4, 32'hFF8, 8'(i), 8'h00, i == 1, 1'b1);
        send_cmd(4'd4, 32'hFF8, 8'd1, 3'd3, 2'b01);
        wait_idle("err4k_done");

        // WRAP with illegal length -> error burst
        for (int i = 0; i < 3; i++) push(4'd5, 32'h40, 8'(i), 8'h00, i == 2, 1'b1);
        send_cmd(4'd5, 32'h40, 8'd2, 3'd3, 2'b10);
        wait_idle("errwrap_done");

        // INCR len 7 with a 3-cycle stall at idx 4; a second command waits meanwhile
        for (int i = 0; i < 8; i++) push(4'd6, 32'h200 + 32'(8 * i), 8'(i), 8'hFF, i == 7, 1'b0);
        send_cmd(4'd6, 32'h200, 8'd7, 3'd3, 2'b01);
        stalls = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (beat_valid && beat_idx == 8'd4 && stalls < 3) begin
                if (stalls > 0)
                    check("stall_frozen", {23'd0, beat_addr, beat_idx, beat_strb, beat_last},
                          {23'd0, 32'h220, 8'd4, 8'hFF, 1'b0});
                check("cmd_ready_in_burst", 64'(cmd_ready), 64'd0);
                if (stalls == 0) begin
                    cmd_valid = 1'b1; cmd_id = 4'd7; cmd_addr = 32'h300;
                    cmd_len = 8'd0; cmd_size = 3'd3; cmd_burst = 2'b01;
                    push(4'd7, 32'h300, 8'd0, 8'hFF, 1'b1, 1'b0);
                end
                beat_ready = 1'b0;
                stalls++;
            end else begin
                beat_ready = 1'b1;
            end
            last_hs = beat_valid && beat_last && beat_ready;
            @(posedge clk); #1;
            if (last_hs) begin
                check("ready_after_last", {62'd0, cmd_ready, beat_valid}, 64'b10);
                done = 1'b1;
            end
        end
        check("stall_burst_done", 64'(done), 64'd1);
        check("stall_cycles", 64'(stalls), 64'd3);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("held_cmd_latency", {59'd0, beat_valid, beat_id}, {59'd0, 1'b1, 4'd7});
        wait_idle("held_cmd_done");

        // Reset after the idx 1 handshake
        push(4'd8, 32'h500, 8'd0, 8'hFF, 1'b0, 1'b0);
        push(4'd8, 32'h508, 8'd1, 8'hFF, 1'b0, 1'b0);
        send_cmd(4'd8, 32'h500, 8'd3, 3'd3, 2'b01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midburst_reset_outputs", out_vec(), RESET_VEC);
        check("midburst_beats_seen", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("ready_after_reset", 64'(cmd_ready), 64'd1);
        push(4'd9, 32'h600, 8'd0, 8'hFF, 1'b0, 1'b0);
        push(4'd9, 32'h608, 8'd1, 8'hFF, 1'b1, 1'b0);
        send_cmd(4'd9, 32'h600, 8'd1, 3'd3, 2'b01);
        wait_idle("post_reset_done");

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end
endmodule
